// File: rtl/ft64_insn_aligner_pkg.sv
// rtl/ft64_insn_aligner_pkg.sv - shared fetch-side constants, fill FSM encoding and length decode
package ft64_insn_aligner_pkg;

  localparam int LINE_BYTES = 16;
  localparam int LINE_BITS  = 128;

  localparam logic [47:0] NOP_INSN = 48'h0000_0000_00EA;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  // Byte length of an instruction from bits [7:6] of its first halfword.
  function automatic logic [4:0] insn_len(input logic [1:0] op);
    case (op)
      2'b00:   return 5'd4;
      2'b01:   return 5'd6;
      default: return 5'd2;
    endcase
  endfunction

endpackage

// File: rtl/ft64_line_extract.sv
// rtl/ft64_line_extract.sv - selects the 48-bit window at a byte offset of two concatenated lines
module ft64_line_extract
  import ft64_insn_aligner_pkg::*;
(
  input  logic [2*LINE_BITS-1:0] lines,
  input  logic [3:0]             off,
  output logic [47:0]            window
);

  assign window = lines[{1'b0, off, 3'b000} +: 48];

endmodule

// File: rtl/ft64_insn_aligner.sv
// rtl/ft64_insn_aligner.sv - two-line buffer feeding the fetch buffer with the instruction at pc
module ft64_insn_aligner
  import ft64_insn_aligner_pkg::*;
#(
  parameter int             AMSB  = 31,
  parameter logic [AMSB:0]  RSTPC = 32'hFFFC0100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AMSB:0]        pc,
  input  logic                 inv_i,
  output logic                 ic_req_o,
  output logic [AMSB:0]        ic_adr_o,
  input  logic                 ic_ack_i,
  input  logic [LINE_BITS-1:0] ic_dat_i,
  output logic [47:0]          insn0,
  output logic                 phit
);

  localparam int TW = AMSB - 3;

  logic [1:0]           slot_v;
  logic [TW-1:0]        slot_tag [2];
  logic [LINE_BITS-1:0] slot_dat [2];
  logic [0:0]           state;
  logic [TW-1:0]        req_tag;

  logic [TW-1:0]        ln;
  logic [TW-1:0]        ln_nxt;
  logic [3:0]           off;
  logic [1:0]           cur_m;
  logic [1:0]           nxt_m;
  logic                 cur_hit;
  logic                 nxt_hit;
  logic [LINE_BITS-1:0] cur_dat;
  logic [LINE_BITS-1:0] nxt_dat;
  logic [47:0]          window;
  logic [4:0]           len;
  logic                 straddle;
  logic                 victim;

  assign ln     = pc[AMSB:4];
  assign ln_nxt = ln + TW'(1);
  assign off    = pc[3:0];

  assign cur_m[0] = slot_v[0] && (slot_tag[0] == ln);
  assign cur_m[1] = slot_v[1] && (slot_tag[1] == ln);
  assign nxt_m[0] = slot_v[0] && (slot_tag[0] == ln_nxt);
  assign nxt_m[1] = slot_v[1] && (slot_tag[1] == ln_nxt);
  assign cur_hit  = |cur_m;
  assign nxt_hit  = |nxt_m;

  // Tags are unique, so at most one slot matches each of ln and ln+1.
  assign cur_dat = cur_m[1] ? slot_dat[1] : slot_dat[0];
  assign nxt_dat = nxt_m[0] ? slot_dat[0] :
                   nxt_m[1] ? slot_dat[1] : '0;

  ft64_line_extract u_extract (
    .lines  ({nxt_dat, cur_dat}),
    .off    (off),
    .window (window)
  );

  assign len      = insn_len(window[7:6]);
  assign straddle = ({1'b0, off} + len) > 5'(LINE_BYTES);
  assign phit     = cur_hit && (!straddle || nxt_hit);
  assign insn0    = phit ? window : NOP_INSN;

  assign ic_req_o = (state == ST_REQ);
  assign ic_adr_o = {req_tag, 4'b0000};

  // The line at pc is never evicted; otherwise fill an empty slot, S0 first.
  always_comb begin
    if (cur_m[0])       victim = 1'b1;
    else if (cur_m[1])  victim = 1'b0;
    else if (!slot_v[0]) victim = 1'b0;
    else if (!slot_v[1]) victim = 1'b1;
    else                victim = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v  <= '0;
      state   <= ST_IDLE;
      req_tag <= RSTPC[AMSB:4];
    end else begin
      case (state)
        ST_IDLE: begin
          if (!cur_hit || !nxt_hit) begin
            state   <= ST_REQ;
            req_tag <= cur_hit ? ln_nxt : ln;
          end
        end
        default: begin
          if (ic_ack_i) begin
            state <= ST_IDLE;
            if (!inv_i) begin
              slot_v[victim]   <= 1'b1;
              slot_tag[victim] <= req_tag;
              slot_dat[victim] <= ic_dat_i;
              if (slot_v[~victim] && (slot_tag[~victim] == req_tag))
                slot_v[~victim] <= 1'b0;
            end
          end
        end
      endcase
      if (inv_i)
        slot_v <= '0;
    end
  end

endmodule
